// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_regfile
// Purpose  : APB responder holding a 32-bit word register file. Word 0 is a
//            read-only ID word, words 1..DEPTH-1 are read/write. Inserts a
//            fixed number of wait states and flags bad accesses on Pslverr.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_regfile #(
  parameter int          SEL_INDEX   = 0,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 1,
  parameter int          ADDR_BITS   = 8,
  parameter logic [31:0] ID_VALUE    = 32'hA5B2_0001
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  localparam int c_IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_wcnt;
  logic [3:0]      w_wcnt_nxt;

  logic [c_IW-1:0] r_idx;
  logic            r_write;
  logic            r_err;
  logic [31:0]     r_wdata;
  logic [31:0]     r_mem [1:DEPTH-1];

  logic            w_psel;
  logic            w_setup;
  logic            w_access;
  logic [31:0]     w_idx_full;
  logic            w_err_setup;
  logic [c_IW-1:0] w_src_idx;
  logic            w_src_err;
  logic [31:0]     w_rdata_sel;
  logic            w_capture;
  logic            w_commit;
  logic [31:0]     w_prdata_nxt;
  logic            w_pready_nxt;
  logic            w_pslverr_nxt;
  logic            w_unused_ok;

  assign w_psel   = Pselx[SEL_INDEX];
  assign w_setup  = w_psel & ~Penable;
  assign w_access = w_psel & Penable;

  // Only the local window of Paddr and one select bit matter; the rest is ignored.
  assign w_unused_ok = ^{Pselx, Paddr};

  // Word index of the live address, widened so range checks need no truncation.
  assign w_idx_full  = 32'(Paddr[ADDR_BITS-1:2]);
  assign w_err_setup = (Paddr[1:0] != 2'b00) ||
                       (w_idx_full >= 32'(DEPTH)) ||
                       (Pwrite && (w_idx_full == 32'd0));

  // With zero wait states the read result is formed straight from the setup
  // phase, before anything has been captured, so pick the live decode then.
  assign w_src_idx   = (r_state == S_IDLE) ? w_idx_full[c_IW-1:0] : r_idx;
  assign w_src_err   = (r_state == S_IDLE) ? w_err_setup : r_err;
  assign w_rdata_sel = w_src_err              ? 32'd0    :
                       (w_src_idx == '0)      ? ID_VALUE :
                                                r_mem[w_src_idx];

  // Next-state, wait counter and next registered output values.
  always_comb begin
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_capture     = 1'b0;
    w_commit      = 1'b0;
    w_pready_nxt  = 1'b0;
    w_prdata_nxt  = 32'd0;
    w_pslverr_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_capture  = 1'b1;
          w_wcnt_nxt = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            w_state_nxt   = S_DONE;
            w_pready_nxt  = 1'b1;
            w_prdata_nxt  = w_rdata_sel;
            w_pslverr_nxt = w_src_err;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!w_psel) begin
          w_state_nxt = S_IDLE;
        end else if (Penable) begin
          if (r_wcnt == 4'd1) begin
            w_state_nxt   = S_DONE;
            w_pready_nxt  = 1'b1;
            w_prdata_nxt  = w_rdata_sel;
            w_pslverr_nxt = w_src_err;
          end else begin
            w_wcnt_nxt = r_wcnt - 4'd1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_commit    = w_access & r_write & ~r_err;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, wait counter and registered bus outputs.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state <= S_IDLE;
      r_wcnt  <= 4'd0;
      Prdata  <= 32'd0;
      Pready  <= 1'b0;
      Pslverr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      Prdata  <= w_prdata_nxt;
      Pready  <= w_pready_nxt;
      Pslverr <= w_pslverr_nxt;
    end
  end

  // Setup-phase capture: later changes of Paddr/Pwdata are deliberately ignored.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_idx   <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= 32'd0;
    end else if (w_capture) begin
      r_idx   <= w_idx_full[c_IW-1:0];
      r_write <= Pwrite;
      r_err   <= w_err_setup;
      r_wdata <= Pwdata;
    end
  end

  // Register file; a write lands only on the completing edge of a good access.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_regfile
// Purpose  : Three register-file slaves on one APB bus (wait states 1, 0, 3),
//            driven by directed and random transfers and compared against a
//            word-array model of each slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regfile;

  localparam logic [31:0] c_ID    = 32'hA5B2_0001;
  localparam int          c_DEPTH = 16;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  logic [31:0] mem_m [3][c_DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 Hclk = ~Hclk;

  function automatic int ws_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      apb_slave_regfile #(
        .SEL_INDEX  (gi),
        .DEPTH      (c_DEPTH),
        .WAIT_STATES(ws_of(gi)),
        .ADDR_BITS  (8),
        .ID_VALUE   (c_ID)
      ) u_dut (
        .Hclk   (Hclk),
        .Hresetn(Hresetn),
        .Pselx  (Pselx),
        .Penable(Penable),
        .Pwrite (Pwrite),
        .Paddr  (Paddr),
        .Pwdata (Pwdata),
        .Prdata (prdata[gi]),
        .Pready (pready[gi]),
        .Pslverr(pslverr[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < c_DEPTH; w++)
        mem_m[s][w] = 32'd0;
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic check_all_quiet(input string tag);
    for (int s = 0; s < 3; s++) begin
      check(tag, {prdata[s][31:2], prdata[s][1:0] | {pready[s], pslverr[s]}}, 32'd0);
    end
  endtask

  // One complete transfer to slave s; returns straight after the completion
  // edge so that a following call forms a back-to-back transfer.
  task automatic xfer(input int s, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    int          idx;
    int          n;
    bit          err;
    logic [31:0] exp_rd;
    idx    = int'(addr[7:2]);
    err    = (addr[1:0] != 2'b00) || (idx >= c_DEPTH) || (wr && idx == 0);
    exp_rd = err ? 32'd0 : ((idx == 0) ? c_ID : mem_m[s][idx]);

    Pselx   = 3'(1 << s);
    Penable = 1'b0;
    Pwrite  = wr;
    Paddr   = addr;
    Pwdata  = wd;
    tick();
    Penable = 1'b1;
    Paddr   = $urandom;
    Pwdata  = $urandom;
    n = 1;
    while (!pready[s] && n < 40) begin
      check("wait_zero", prdata[s] | {31'd0, pslverr[s]}, 32'd0);
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(ws_of(s) + 1));
    check("slverr", {31'd0, pslverr[s]}, {31'd0, err});
    if (!wr) check("rdata", prdata[s], exp_rd);
    for (int o = 0; o < 3; o++)
      if (o != s) check("other_ready", {31'd0, pready[o]}, 32'd0);
    if (wr && !err) mem_m[s][idx] = wd;
    tick();
    Pselx   = 3'b000;
    Penable = 1'b0;
    check("ready_pulse", {31'd0, pready[s]}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  lo;
    Hresetn = 1'b0;
    Pselx   = 3'b000;
    Penable = 1'b0;
    Pwrite  = 1'b0;
    Paddr   = 32'd0;
    Pwdata  = 32'd0;
    model_reset();
    repeat (3) tick();
    check_all_quiet("reset_out");
    Hresetn = 1'b1;
    tick();

    // Reset during a completing read clears outputs immediately.
    xfer(1, 1'b1, 32'h04, 32'hCAFE_F00D);
    Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h04;
    tick();
    Penable = 1'b1;
    check("pre_reset_rdata", prdata[1], 32'hCAFE_F00D);
    Hresetn = 1'b0;
    #1;
    check_all_quiet("async_reset");
    Pselx = 3'b000; Penable = 1'b0;
    model_reset();
    tick();
    Hresetn = 1'b1;
    tick();

    // Reset mid-WAIT of a write drops the write.
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h04; Pwdata = 32'h1234_5678;
    tick();
    Penable = 1'b1;
    Hresetn = 1'b0;
    #1;
    check_all_quiet("reset_mid_wait");
    Pselx = 3'b000; Penable = 1'b0;
    tick();
    Hresetn = 1'b1;
    tick();
    xfer(0, 1'b0, 32'h04, 32'd0);
    xfer(1, 1'b0, 32'h04, 32'd0);

    // Write/read, ID word and error decode.
    xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h08, 32'd0);
    for (int s = 0; s < 3; s++) begin
      xfer(s, 1'b0, 32'h00, 32'd0);
      xfer(s, 1'b1, 32'h00, 32'hFFFF_FFFF);
      xfer(s, 1'b0, 32'h00, 32'd0);
    end
    xfer(0, 1'b1, 32'h04, 32'h0BAD_0001);
    xfer(0, 1'b0, 32'h40, 32'd0);
    xfer(0, 1'b1, 32'h05, 32'h5555_5555);
    xfer(0, 1'b0, 32'h05, 32'd0);
    xfer(0, 1'b0, 32'h04, 32'd0);

    // Another slave's transfer leaves slave 0 alone.
    xfer(1, 1'b1, 32'h08, 32'h7777_0000);
    xfer(0, 1'b0, 32'h08, 32'd0);

    // Access phase without a setup phase is ignored.
    Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h0C; Pwdata = 32'h9999_9999;
    repeat (4) begin
      tick();
      check("no_setup_ready", {31'd0, pready[0]}, 32'd0);
    end
    Pselx = 3'b000; Penable = 1'b0;
    tick();
    xfer(0, 1'b0, 32'h0C, 32'd0);

    // Deselect in WAIT aborts with no write.
    Pselx = 3'b100; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h14; Pwdata = 32'h4242_4242;
    tick();
    Penable = 1'b1;
    tick();
    Pselx = 3'b000; Penable = 1'b0;
    tick();
    check("abort_ready", {31'd0, pready[2]}, 32'd0);
    tick();
    check("abort_ready2", {31'd0, pready[2]}, 32'd0);
    xfer(2, 1'b0, 32'h14, 32'd0);

    // Back-to-back writes on the zero- and three-wait-state slaves.
    for (int s = 1; s < 3; s++) begin
      xfer(s, 1'b1, 32'h0C, 32'h1);
      xfer(s, 1'b1, 32'h10, 32'h2);
      xfer(s, 1'b0, 32'h0C, 32'd0);
      xfer(s, 1'b0, 32'h10, 32'd0);
    end

    // Random traffic.
    for (int t = 0; t < 300; t++) begin
      r = $urandom;
      if ($urandom_range(0, 7) == 0) lo = 8'($urandom_range(0, 255));
      else                           lo = 8'($urandom_range(0, 17) * 4);
      xfer(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), {r[31:8], lo}, $urandom);
      if ($urandom_range(0, 3) == 0) tick();
    end

    // Final read-back of every word of every slave.
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < c_DEPTH; w++)
        xfer(s, 1'b0, 32'(w * 4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
